// File: rtl/count_sweep_ctrl.sv
// Sweep sequencer for an 8-bit loadable up/down counter that has no enable.
// Generates the counter's load/direction/data controls and reports busy/done/cfg_err.
module count_sweep_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LOOPW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] cfg_lo,
    input  logic [WIDTH-1:0] cfg_hi,
    input  logic [1:0]       cfg_mode,
    input  logic [LOOPW-1:0] cfg_loops,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_load,
    output logic             cnt_up_not_down,
    output logic [WIDTH-1:0] cnt_data,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [LOOPW-1:0] loop_cnt
);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DN   = 2'b01;
    localparam logic [1:0] MODE_SAW  = 2'b10;
    localparam logic [1:0] MODE_TRI  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN_UP,
        S_RUN_DN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [1:0]       mode_q, mode_d;
    logic [LOOPW-1:0] loops_q, loops_d;
    logic [LOOPW-1:0] loop_cnt_q, loop_cnt_d;
    logic             busy_q, done_q, cfg_err_q, cfg_err_d;

    logic [LOOPW-1:0] loop_inc;
    logic             limit_hit;
    logic             flat;

    assign loop_inc  = LOOPW'(loop_cnt_q + 1'b1);
    assign limit_hit = (loops_q != '0) && (loop_inc == loops_q);
    assign flat      = (lo_q == hi_q);

    // Next state, latched config and counter controls; default is the hold rule.
    always_comb begin
        state_d         = state_q;
        lo_d            = lo_q;
        hi_d            = hi_q;
        mode_d          = mode_q;
        loops_d         = loops_q;
        loop_cnt_d      = loop_cnt_q;
        cfg_err_d       = 1'b0;
        cnt_load        = 1'b1;
        cnt_data        = cnt_value;
        cnt_up_not_down = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_lo <= cfg_hi) begin
                        lo_d       = cfg_lo;
                        hi_d       = cfg_hi;
                        mode_d     = cfg_mode;
                        loops_d    = cfg_loops;
                        loop_cnt_d = '0;
                        state_d    = S_LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_data = (mode_q == MODE_DN) ? hi_q : lo_q;
                    state_d  = (mode_q == MODE_DN) ? S_RUN_DN : S_RUN_UP;
                end
            end
            S_RUN_UP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_value >= hi_q) begin
                    if (flat || mode_q == MODE_UP || mode_q == MODE_DN) begin
                        loop_cnt_d = LOOPW'(1);
                        state_d    = S_DONE;
                    end else if (mode_q == MODE_SAW) begin
                        loop_cnt_d = loop_inc;
                        if (limit_hit) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_data = lo_q;
                        end
                    end else begin
                        // Triangle reverses in place: next value is hi_q - 1.
                        cnt_load        = 1'b0;
                        cnt_up_not_down = 1'b0;
                        state_d         = S_RUN_DN;
                    end
                end else begin
                    cnt_load = 1'b0;
                end
            end
            S_RUN_DN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_value <= lo_q) begin
                    if (flat || mode_q != MODE_TRI) begin
                        loop_cnt_d = LOOPW'(1);
                        state_d    = S_DONE;
                    end else begin
                        loop_cnt_d = loop_inc;
                        if (limit_hit) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_load = 1'b0;
                            state_d  = S_RUN_UP;
                        end
                    end
                end else begin
                    cnt_load        = 1'b0;
                    cnt_up_not_down = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lo_q       <= '0;
            hi_q       <= '0;
            mode_q     <= '0;
            loops_q    <= '0;
            loop_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            mode_q     <= mode_d;
            loops_q    <= loops_d;
            loop_cnt_q <= loop_cnt_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign cfg_err  = cfg_err_q;
    assign loop_cnt = loop_cnt_q;

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Bench for count_sweep_ctrl driving a behavioural 8-bit loadable up/down counter.
// Expected per-cycle counter/busy/done values are queued at stimulus time and popped each cycle.
module tb_count_sweep_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cnt_rst_n;
    logic       start;
    logic       abort;
    logic [7:0] cfg_lo;
    logic [7:0] cfg_hi;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_loops;
    logic [7:0] cnt_value;
    logic       cnt_load;
    logic       cnt_up_not_down;
    logic [7:0] cnt_data;
    logic       busy;
    logic       done;
    logic       cfg_err;
    logic [7:0] loop_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] cnt;
        logic       busy;
        logic       done;
        logic       chk_loop;
        logic [7:0] loop;
    } exp_t;

    exp_t sb[$];

    count_sweep_ctrl #(.WIDTH(8), .LOOPW(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .cfg_lo          (cfg_lo),
        .cfg_hi          (cfg_hi),
        .cfg_mode        (cfg_mode),
        .cfg_loops       (cfg_loops),
        .cnt_value       (cnt_value),
        .cnt_load        (cnt_load),
        .cnt_up_not_down (cnt_up_not_down),
        .cnt_data        (cnt_data),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err),
        .loop_cnt        (loop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter being controlled: load wins, otherwise count in the given direction.
    always_ff @(posedge clk or negedge cnt_rst_n) begin
        if (!cnt_rst_n)           cnt_value <= 8'd0;
        else if (cnt_load)        cnt_value <= cnt_data;
        else if (cnt_up_not_down) cnt_value <= cnt_value + 8'd1;
        else                      cnt_value <= cnt_value - 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] c, input logic b, input logic d,
                        input logic cl, input logic [7:0] l);
        exp_t e;
        e.cnt = c; e.busy = b; e.done = d; e.chk_loop = cl; e.loop = l;
        sb.push_back(e);
    endtask

    // Advance one cycle per queued entry and compare.
    task automatic drain(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            step();
            e = sb.pop_front();
            chk({tag, "_cnt"},  32'(cnt_value), 32'(e.cnt));
            chk({tag, "_busy"}, 32'(busy),      32'(e.busy));
            chk({tag, "_done"}, 32'(done),      32'(e.done));
            if (e.chk_loop) chk({tag, "_loop"}, 32'(loop_cnt), 32'(e.loop));
        end
    endtask

    // Present config with a one-cycle start; returns one cycle later (T1).
    task automatic kick(input logic [7:0] lo, input logic [7:0] hi,
                        input logic [1:0] mode, input logic [7:0] loops);
        cfg_lo = lo; cfg_hi = hi; cfg_mode = mode; cfg_loops = loops;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cnt_rst_n = 1'b0;
        start = 1'b0; abort = 1'b0;
        cfg_lo = '0; cfg_hi = '0; cfg_mode = '0; cfg_loops = '0;
        repeat (2) step();

        chk("rst_busy",    32'(busy),            32'(0));
        chk("rst_done",    32'(done),            32'(0));
        chk("rst_cfg_err", 32'(cfg_err),         32'(0));
        chk("rst_loop",    32'(loop_cnt),        32'(0));
        chk("rst_load",    32'(cnt_load),        32'(1));
        chk("rst_dir",     32'(cnt_up_not_down), 32'(1));
        chk("rst_data",    32'(cnt_data),        32'(0));

        @(negedge clk);
        rst_n = 1'b1; cnt_rst_n = 1'b1;
        step();

        // Single-up 3..6
        kick(8'd3, 8'd6, 2'b00, 8'd0);
        chk("up_t1_busy", 32'(busy),     32'(1));
        chk("up_t1_load", 32'(cnt_load), 32'(1));
        chk("up_t1_data", 32'(cnt_data), 32'(3));
        push(8'd3, 1'b1, 1'b0, 1'b0, 8'd0);
        push(8'd4, 1'b1, 1'b0, 1'b0, 8'd0);
        push(8'd5, 1'b1, 1'b0, 1'b0, 8'd0);
        push(8'd6, 1'b1, 1'b0, 1'b0, 8'd0);
        drain("up");
        chk("up_t5_load", 32'(cnt_load), 32'(1));
        chk("up_t5_data", 32'(cnt_data), 32'(6));
        push(8'd6, 1'b1, 1'b1, 1'b0, 8'd0);
        push(8'd6, 1'b0, 1'b0, 1'b1, 8'd1);
        push(8'd6, 1'b0, 1'b0, 1'b1, 8'd1);
        drain("up_end");

        // Sawtooth 10..12, two loops
        kick(8'd10, 8'd12, 2'b10, 8'd2);
        push(8'd10, 1'b1, 1'b0, 1'b1, 8'd0);
        push(8'd11, 1'b1, 1'b0, 1'b1, 8'd0);
        push(8'd12, 1'b1, 1'b0, 1'b1, 8'd0);
        push(8'd10, 1'b1, 1'b0, 1'b1, 8'd1);
        push(8'd11, 1'b1, 1'b0, 1'b1, 8'd1);
        push(8'd12, 1'b1, 1'b0, 1'b1, 8'd1);
        push(8'd12, 1'b1, 1'b1, 1'b1, 8'd2);
        push(8'd12, 1'b0, 1'b0, 1'b1, 8'd2);
        push(8'd12, 1'b0, 1'b0, 1'b1, 8'd2);
        drain("saw");

        // Triangle 0..3, one loop; turnaround at hi costs no cycle
        kick(8'd0, 8'd3, 2'b11, 8'd1);
        push(8'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        push(8'd1, 1'b1, 1'b0, 1'b0, 8'd0);
        push(8'd2, 1'b1, 1'b0, 1'b0, 8'd0);
        push(8'd3, 1'b1, 1'b0, 1'b0, 8'd0);
        push(8'd2, 1'b1, 1'b0, 1'b0, 8'd0);
        push(8'd1, 1'b1, 1'b0, 1'b0, 8'd0);
        push(8'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        push(8'd0, 1'b1, 1'b1, 1'b1, 8'd1);
        push(8'd0, 1'b0, 1'b0, 1'b1, 8'd1);
        drain("tri");

        // Triangle with lo == hi == 5
        kick(8'd5, 8'd5, 2'b11, 8'd0);
        push(8'd5, 1'b1, 1'b0, 1'b0, 8'd0);
        push(8'd5, 1'b1, 1'b1, 1'b1, 8'd1);
        push(8'd5, 1'b0, 1'b0, 1'b1, 8'd1);
        push(8'd5, 1'b0, 1'b0, 1'b1, 8'd1);
        drain("flat");

        // Rejected start: lo > hi
        kick(8'd9, 8'd2, 2'b00, 8'd0);
        chk("err_pulse", 32'(cfg_err), 32'(1));
        chk("err_busy",  32'(busy),    32'(0));
        step();
        chk("err_clear", 32'(cfg_err), 32'(0));
        chk("err_busy2", 32'(busy),    32'(0));
        chk("err_hold",  32'(cnt_value), 32'(5));

        // Infinite sawtooth 0..1; loop_cnt wraps past 255
        kick(8'd0, 8'd1, 2'b10, 8'd0);
        for (int n = 2; n <= 601; n++)
            push(8'((n - 2) % 2), 1'b1, 1'b0, 1'b1, 8'(((n - 2) / 2) % 256));
        drain("inf");
        abort = 1'b1;
        #1;
        chk("abort_load", 32'(cnt_load), 32'(1));
        chk("abort_data", 32'(cnt_data), 32'(1));
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy),      32'(0));
        chk("abort_done", 32'(done),      32'(0));
        chk("abort_cnt",  32'(cnt_value), 32'(1));
        chk("abort_loop", 32'(loop_cnt),  32'(43));
        step();
        chk("abort_done2", 32'(done),      32'(0));
        chk("abort_cnt2",  32'(cnt_value), 32'(1));
        chk("abort_load2", 32'(cnt_load),  32'(1));

        // Async reset in the middle of a single-down sweep
        kick(8'd2, 8'd9, 2'b01, 8'd0);
        push(8'd9, 1'b1, 1'b0, 1'b0, 8'd0);
        push(8'd8, 1'b1, 1'b0, 1'b0, 8'd0);
        push(8'd7, 1'b1, 1'b0, 1'b0, 8'd0);
        drain("dn");
        chk("dn_dir", 32'(cnt_up_not_down), 32'(0));
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy),     32'(0));
        chk("mrst_done", 32'(done),     32'(0));
        chk("mrst_load", 32'(cnt_load), 32'(1));
        chk("mrst_data", 32'(cnt_data), 32'(7));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("post_cnt",  32'(cnt_value), 32'(7));
        chk("post_load", 32'(cnt_load),  32'(1));
        chk("post_data", 32'(cnt_data),  32'(7));
        chk("post_busy", 32'(busy),      32'(0));
        chk("post_loop", 32'(loop_cnt),  32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
